serial_echo_responder: RTL and testbench

Responder end of the single-wire x/z test link. The bench drives framed serial words on `x`. This block receives each word, checks its framing, reports it on a parallel port, and then echoes the same word back on `z` with identical framing after a fixed turnaround gap. It sits at the leaf of a test hierarchy, where the top-level driver owns `x` and observes `z`.

---
 rtl/serial_echo_responder_pkg.sv | 20 ++
 rtl/serial_echo_responder_bit_timer.sv | 39 +++
 rtl/serial_echo_responder.sv | 204 ++++++++++++++++++++
 tb/tb_serial_echo_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_echo_responder_pkg.sv
// Shared definitions for the serial echo responder.
//   state_e    : receive / turnaround / transmit phases of the responder FSM
//   IDLE_LEVEL : line level of an idle x/z wire (also the stop-bit level)
package serial_echo_responder_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    WAIT_HI,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_echo_responder_bit_timer.sv
// Loadable down-counter shared by every timed phase of the responder.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val into the counter this cycle
//   load_val   : period minus one; expire is seen load_val+1 edges after load
//   expire     : high while the count sits at zero
module bit_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count saturates at zero; the FSM reloads on every expire it consumes.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/serial_echo_responder.sv
// Responder end of the single-wire x/z test link. Receives a framed word on x
// (start 0, DATA_W bits LSB first, stop 1, BIT_CYC clocks per bit), reports it
// on rx_data/rx_valid, then echoes it on z after a TURN_CYC-clock gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   x          : serial input, idles high, asynchronous to clk
//   z          : serial echo output, idles high
//   busy       : high whenever the responder is not idle
//   rx_data    : last word received with a good stop bit
//   rx_valid   : one-cycle pulse when rx_data updates
//   frm_err    : one-cycle pulse when the stop bit is sampled low
module serial_echo_responder
  import serial_echo_responder_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BIT_CYC  = 16,
  parameter int unsigned TURN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x,
  output logic              z,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frm_err
);

  // Timer is sized for the longer of a bit period and the turnaround phase.
  localparam int unsigned TMR_W = (TURN_CYC >= BIT_CYC) ? $clog2(TURN_CYC + 1) + 1
                                                        : $clog2(BIT_CYC) + 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(BIT_CYC / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_LD   = TMR_W'(BIT_CYC - 1);
  // TURN lasts TURN_CYC+1 cycles: the rx_valid cycle plus TURN_CYC idle clocks.
  localparam logic [TMR_W-1:0] TURN_LD  = TMR_W'(TURN_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic              sync1_q;
  logic              xs_q;
  state_e            state_q,    state_d;
  logic [IDX_W-1:0]  bit_idx_q,  bit_idx_d;
  logic [DATA_W-1:0] shreg_q,    shreg_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frm_err_q,  frm_err_d;
  logic              z_q,        z_d;
  logic              busy_q,     busy_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_LEVEL;
      xs_q    <= IDLE_LEVEL;
    end else begin
      sync1_q <= x;
      xs_q    <= sync1_q;
    end
  end

  bit_timer #(
    .CNT_W (TMR_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    frm_err_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = BIT_LD;

    unique case (state_q)
      IDLE: begin
        if (xs_q != IDLE_LEVEL) begin
          state_d  = RX_START;
          tmr_load = 1'b1;
          tmr_val  = HALF_LD;
        end
      end
      RX_START: begin
        if (tmr_expire) begin
          if (xs_q == IDLE_LEVEL) begin
            state_d = IDLE;
          end else begin
            state_d   = RX_DATA;
            tmr_load  = 1'b1;
            bit_idx_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (tmr_expire) begin
          // LSB arrives first, so shift in from the top.
          shreg_d             = shreg_q >> 1;
          shreg_d[DATA_W-1]   = xs_q;
          tmr_load            = 1'b1;
          bit_idx_d           = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tmr_expire) begin
          if (xs_q == IDLE_LEVEL) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            state_d    = TURN;
            tmr_load   = 1'b1;
            tmr_val    = TURN_LD;
          end else begin
            frm_err_d = 1'b1;
            state_d   = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (xs_q == IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end
      TURN: begin
        if (tmr_expire) begin
          state_d  = TX_START;
          tmr_load = 1'b1;
        end
      end
      TX_START: begin
        if (tmr_expire) begin
          state_d   = TX_DATA;
          tmr_load  = 1'b1;
          bit_idx_d = '0;
        end
      end
      TX_DATA: begin
        if (tmr_expire) begin
          tmr_load  = 1'b1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered z and busy
    // change on the same edge as the state itself.
    z_d = IDLE_LEVEL;
    if (state_d == TX_START) begin
      z_d = ~IDLE_LEVEL;
    end else if (state_d == TX_DATA) begin
      z_d = rx_data_q[bit_idx_d];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      frm_err_q  <= 1'b0;
      z_q        <= IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frm_err_q  <= frm_err_d;
      z_q        <= z_d;
      busy_q     <= busy_d;
    end
  end

  assign z        = z_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_serial_echo_responder.sv
// Scoreboard bench for serial_echo_responder: stimulus pushes expected words,
// independent monitors decode rx_valid/frm_err pulses and the z echo frames.
module tb_serial_echo_responder;

  localparam int DATA_W   = 8;
  localparam int BIT_CYC  = 16;
  localparam int TURN_CYC = 4;
  localparam int ECHO_LEN = (DATA_W + 2) * BIT_CYC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              x;
  logic              z;
  logic              busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frm_err;

  serial_echo_responder #(
    .DATA_W   (DATA_W),
    .BIT_CYC  (BIT_CYC),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .z        (z),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int last_valid_cyc = -1000;

  // Reference model state: what the responder should report and echo.
  logic [DATA_W-1:0] exp_rx[$];
  logic [DATA_W-1:0] exp_err[$];
  logic [DATA_W-1:0] exp_echo[$];
  logic [DATA_W-1:0] model_rx_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // ---------------- parallel-port monitor ----------------
  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rx_valid === 1'b1 && frm_err === 1'b1) flag("rx_valid_and_frm_err_together");
        if (rx_valid === 1'b1) begin
          n_valid++;
          last_valid_cyc = cyc;
          if (exp_rx.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_valid_unexpected: rx_data=0x%0h, expected no pulse", rx_data);
          end else begin
            chk("rx_data", rx_data, exp_rx.pop_front());
          end
        end
        if (frm_err === 1'b1) begin
          if (exp_err.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frm_err_unexpected: got pulse, expected none");
          end else begin
            chk("rx_data_hold_on_err", rx_data, exp_err.pop_front());
          end
        end
      end
    end
  end

  // ---------------- echo monitor ----------------
  initial begin : echo_mon
    logic              z_prev;
    int                f;
    int                off;
    bit                aborted;
    logic [DATA_W-1:0] got;
    z_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        z_prev = 1'b1;
      end else if (z_prev === 1'b1 && z === 1'b0) begin
        f = cyc;
        got = '0;
        aborted = 1'b0;
        off = 0;
        chk("echo_turnaround", f - last_valid_cyc, TURN_CYC + 1);
        while (off < ECHO_LEN) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          off = cyc - f;
          if (off % BIT_CYC == BIT_CYC / 2) begin
            if (off / BIT_CYC == 0) chk("echo_start_bit", z, 1'b0);
            else if (off / BIT_CYC <= DATA_W) got[off / BIT_CYC - 1] = z;
            else chk("echo_stop_bit", z, 1'b1);
          end
          if (off == ECHO_LEN - 1) chk("echo_busy_hold", busy, 1'b1);
        end
        if (!aborted) begin
          chk("echo_busy_end", busy, 1'b0);
          chk("echo_z_idle", z, 1'b1);
          if (exp_echo.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL echo_unexpected: got word 0x%0h, expected no echo", got);
          end else begin
            chk("echo_data", got, exp_echo.pop_front());
          end
        end
        z_prev = z;
      end else begin
        z_prev = z;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    x = v;
    repeat (n) tick();
  endtask

  task automatic send_raw(input logic [DATA_W-1:0] d, input logic stop_v, input int extra);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i], BIT_CYC);
    drive_bit(stop_v, BIT_CYC + extra);
    x = 1'b1;
  endtask

  // A frame sent to an idle responder is reported and echoed if its stop bit
  // is high; otherwise it raises frm_err and rx_data keeps its old value.
  task automatic send_frame(input logic [DATA_W-1:0] d, input bit good, input int extra);
    if (good) begin
      exp_rx.push_back(d);
      exp_echo.push_back(d);
      model_rx_data = d;
    end else begin
      exp_err.push_back(model_rx_data);
    end
    send_raw(d, good ? 1'b1 : 1'b0, extra);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic wait_zfall(input string name, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (z !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (z !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_zfall_timeout: z=%b after %0d cycles, expected 0", name, z, n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int                hi;
    int                n;
    int                v0;
    logic [DATA_W-1:0] d;
    bit                good;
    int                extra;
    int                gap;

    x = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_z", z, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frm_err", frm_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 0);
    wait_idle("a5", 600);
    chk("rx_data_a5", rx_data, 8'hA5);

    // Three-clock low glitch
    repeat (5) tick();
    hi = 0;
    x = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) x = 1'b1;
      tick();
      if (busy === 1'b1) hi++;
    end
    chk("glitch_busy_cycles", hi, BIT_CYC / 2);
    chk("glitch_rx_data_hold", rx_data, 8'hA5);

    // Framing error on 0x3C, x released 20 clocks after the stop bit period
    repeat (3) tick();
    send_frame(8'h3C, 1'b0, 20);
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("wait_hi_release_2_to_3", (n >= 2 && n <= 3), 1'b1);
    chk("frm_err_seen", exp_err.size(), 0);
    chk("rx_data_after_err", rx_data, 8'hA5);

    // 0x0F frame started during the 0x81 echo data phase is lost
    repeat (2) tick();
    v0 = n_valid;
    send_frame(8'h81, 1'b1, 0);
    wait_zfall("81", 100);
    repeat (BIT_CYC + 2) tick();
    send_raw(8'h0F, 1'b1, 0);
    wait_idle("81_overlap", 600);
    chk("overlap_single_valid", n_valid - v0, 1);
    repeat (2) tick();
    send_frame(8'h0F, 1'b1, 0);
    wait_idle("0f", 600);

    // Reset during echo data bit 3 of 0xC3 (bit 3 is 0 on the wire)
    repeat (2) tick();
    send_frame(8'hC3, 1'b1, 0);
    wait_zfall("c3", 100);
    repeat (4 * BIT_CYC + BIT_CYC / 2) tick();
    chk("pre_reset_z_bit3", z, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_z", z, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_rx_data", rx_data, 0);
    repeat (3) tick();
    exp_echo.delete();
    model_rx_data = '0;
    rst_n = 1'b1;
    repeat (3) tick();
    send_frame(8'h55, 1'b1, 0);
    wait_idle("55", 600);

    // Back-to-back 0xFF then 0x00
    v0 = n_valid;
    repeat (2) tick();
    send_frame(8'hFF, 1'b1, 0);
    wait_idle("ff", 600);
    repeat (2) tick();
    send_frame(8'h00, 1'b1, 0);
    wait_idle("00", 600);
    chk("b2b_valid_count", n_valid - v0, 2);

    // Randomized frames with occasional bad stop bits
    for (int k = 0; k < 12; k++) begin
      d     = DATA_W'($urandom);
      good  = ($urandom_range(0, 3) != 0);
      extra = good ? 0 : int'($urandom_range(0, 30));
      gap   = $urandom_range(2, 10);
      repeat (gap) tick();
      send_frame(d, good, extra);
      wait_idle("random", 600);
    end

    repeat (5) tick();
    chk("drain_rx", exp_rx.size(), 0);
    chk("drain_err", exp_err.size(), 0);
    chk("drain_echo", exp_echo.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
